// File: rtl/fifo_reader.sv
// fifo_reader: turns a raw active-low pushbutton into single-word FIFO reads.
// The button is synchronized and edge-detected into a one-cycle pop request.
// A four-state FSM issues one read strobe, waits out the FIFO read latency,
// and then captures the returned word into data_out.
// Optional feature macro: FIFO_READER_UNDERFLOW_EN builds the sticky underflow
// flag. Without it, underflow is tied low.
module fifo_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1   // legal 1..3
) (
  input  logic                  clk,
  input  logic                  reset,       // asynchronous, active-low
  input  logic                  pop_n,       // raw button, low when pressed
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  underflow
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  // Counter value at which WAIT has spent READ_LATENCY-1 cycles.
  localparam logic [1:0] LAT_LAST = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

  state_t                state_reg, state_next;
  logic [1:0]            lat_cnt_reg, lat_cnt_next;
  logic                  sync1_reg, sync2_reg, sync3_reg;
  logic                  pop_req;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  data_valid_reg;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // All three reset to 1 (button released), so reset never fakes a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      sync3_reg <= 1'b1;
    end else begin
      sync1_reg <= pop_n;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  // A press is a 1->0 step on the synchronized button.
  assign pop_req = sync3_reg & ~sync2_reg;

  // FSM state and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
    end
  end

  // Next-state logic and the read strobe. Requests seen outside IDLE are dropped.
  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    fifo_read    = 1'b0;
    case (state_reg)
      IDLE: begin
        lat_cnt_next = 2'd0;
        if (pop_req && !fifo_empty) state_next = ISSUE;
      end
      ISSUE: begin
        // Never strobe an empty FIFO. The transaction still completes, because
        // emptiness is only decided in IDLE.
        fifo_read    = ~fifo_empty;
        lat_cnt_next = 2'd0;
        state_next   = (READ_LATENCY > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        if (lat_cnt_reg == LAT_LAST) begin
          lat_cnt_next = 2'd0;
          state_next   = CAPTURE;
        end else begin
          lat_cnt_next = lat_cnt_reg + 2'd1;
        end
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the FIFO word in CAPTURE. data_valid marks the first cycle it is shown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      data_valid_reg <= (state_reg == CAPTURE);
      if (state_reg == CAPTURE) data_out_reg <= fifo_data;
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign busy       = (state_reg != IDLE);

`ifdef FIFO_READER_UNDERFLOW_EN
  logic underflow_reg;

  // Sticky flag: set when a press is accepted in IDLE but the FIFO is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) underflow_reg <= 1'b0;
    else if (state_reg == IDLE && pop_req && fifo_empty) underflow_reg <= 1'b1;
  end

  assign underflow = underflow_reg;
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader. Two instances share all inputs: one with
// READ_LATENCY=1 and one with READ_LATENCY=3.
module tb_fifo_reader;

`ifdef FIFO_READER_UNDERFLOW_EN
  localparam logic UF_EN = 1'b1;
`else
  localparam logic UF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pop_n;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  logic       rd1, dv1, busy1, uf1;
  logic [7:0] dout1;
  logic       rd3, dv3, busy3, uf3;
  logic [7:0] dout3;

  int total = 0;
  int bad   = 0;
  int rd1_cnt = 0, dv1_cnt = 0, rd3_cnt = 0, dv3_cnt = 0;
  logic prev_rd1 = 1'b0, prev_rd3 = 1'b0;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(8), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .pop_n(pop_n), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(rd1), .data_out(dout1),
    .data_valid(dv1), .busy(busy1), .underflow(uf1));

  fifo_reader #(.DATA_WIDTH(8), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .pop_n(pop_n), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(rd3), .data_out(dout3),
    .data_valid(dv3), .busy(busy3), .underflow(uf3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse counters and strobe invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (rd1) begin
      rd1_cnt++;
      check("rd1_back_to_back", 32'(prev_rd1), 32'd0);
      check("rd1_while_empty", 32'(fifo_empty), 32'd0);
    end
    if (rd3) begin
      rd3_cnt++;
      check("rd3_back_to_back", 32'(prev_rd3), 32'd0);
      check("rd3_while_empty", 32'(fifo_empty), 32'd0);
    end
    if (dv1) dv1_cnt++;
    if (dv3) dv3_cnt++;
    prev_rd1 = rd1;
    prev_rd3 = rd3;
  end

  task automatic wait_rd3(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rd3) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rd3_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic       empty;
    logic [7:0] data;
    int         reads;
    logic [7:0] dout;
    logic       uf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int b_r1, b_d1, b_r3, b_d3;
    bit ok;

    vecs[0] = '{1'b0, 8'hA5, 1, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 8'h77, 0, 8'hA5, UF_EN};
    vecs[2] = '{1'b0, 8'h01, 1, 8'h01, UF_EN};
    vecs[3] = '{1'b0, 8'h02, 1, 8'h02, UF_EN};
    vecs[4] = '{1'b0, 8'h03, 1, 8'h03, UF_EN};
    vecs[5] = '{1'b0, 8'h04, 1, 8'h04, UF_EN};

    reset = 1'b0; pop_n = 1'b1; fifo_empty = 1'b0; fifo_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_dout1", 32'(dout1), 32'h0);
    check("rst_dv1", 32'(dv1), 32'h0);
    check("rst_busy1", 32'(busy1), 32'h0);
    check("rst_rd1", 32'(rd1), 32'h0);
    check("rst_uf1", 32'(uf1), 32'h0);
    check("rst_dout3", 32'(dout3), 32'h0);
    check("rst_busy3", 32'(busy3), 32'h0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("no_read_after_reset", rd1_cnt + rd3_cnt, 0);

    // Table: one press per row, 6 cycles held and 4 released.
    for (int i = 0; i < 6; i++) begin
      fifo_empty = vecs[i].empty;
      fifo_data  = vecs[i].data;
      b_r1 = rd1_cnt; b_d1 = dv1_cnt; b_r3 = rd3_cnt; b_d3 = dv3_cnt;
      pop_n = 1'b0;
      repeat (6) @(negedge clk);
      pop_n = 1'b1;
      repeat (4) @(negedge clk);
      check($sformatf("row%0d_reads1", i), rd1_cnt - b_r1, vecs[i].reads);
      check($sformatf("row%0d_valid1", i), dv1_cnt - b_d1, vecs[i].reads);
      check($sformatf("row%0d_dout1", i), 32'(dout1), 32'(vecs[i].dout));
      check($sformatf("row%0d_uf1", i), 32'(uf1), 32'(vecs[i].uf));
      check($sformatf("row%0d_reads3", i), rd3_cnt - b_r3, vecs[i].reads);
      check($sformatf("row%0d_valid3", i), dv3_cnt - b_d3, vecs[i].reads);
      check($sformatf("row%0d_dout3", i), 32'(dout3), 32'(vecs[i].dout));
      check($sformatf("row%0d_uf3", i), 32'(uf3), 32'(vecs[i].uf));
      $display("row %0d: empty=%0b data=%02h dout1=%02h dout3=%02h uf1=%0b", i,
               vecs[i].empty, vecs[i].data, dout1, dout3, uf1);
    end

    // Latency 3: data presented 3 cycles after the strobe, visible 4 cycles after.
    fifo_empty = 1'b0; fifo_data = 8'h00;
    pop_n = 1'b0;
    wait_rd3(ok);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("lat3_busy_t%0d", k), 32'(busy3), (k <= 3) ? 32'd1 : 32'd0);
      check($sformatf("lat3_valid_t%0d", k), 32'(dv3), (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("lat3_dout_t%0d", k), 32'(dout3), (k <= 3) ? 32'h04 : 32'h3C);
      if (k == 3) fifo_data = 8'h3C;
    end
    pop_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("latency3: dout3=%02h", dout3);

    // Hold the button for 100 cycles: a single read.
    b_r1 = rd1_cnt; b_r3 = rd3_cnt; b_d3 = dv3_cnt;
    pop_n = 1'b0;
    repeat (100) @(negedge clk);
    pop_n = 1'b1;
    repeat (5) @(negedge clk);
    check("hold_reads1", rd1_cnt - b_r1, 1);
    check("hold_reads3", rd3_cnt - b_r3, 1);
    check("hold_valid3", dv3_cnt - b_d3, 1);
    $display("hold100: reads1=%0d reads3=%0d", rd1_cnt - b_r1, rd3_cnt - b_r3);

    // Second press lands while the latency-3 instance is in CAPTURE: dropped there.
    b_r1 = rd1_cnt; b_r3 = rd3_cnt;
    pop_n = 1'b0;
    repeat (3) @(negedge clk);
    pop_n = 1'b1;
    @(negedge clk);
    pop_n = 1'b0;
    repeat (10) @(negedge clk);
    pop_n = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_drop_reads3", rd3_cnt - b_r3, 1);
    check("busy_drop_reads1", rd1_cnt - b_r1, 2);
    check("busy_drop_uf3", 32'(uf3), 32'(UF_EN));
    $display("busy drop: reads1=%0d reads3=%0d", rd1_cnt - b_r1, rd3_cnt - b_r3);

    // Reset asserted while the latency-3 instance sits in WAIT.
    fifo_data = 8'h11;
    pop_n = 1'b0;
    wait_rd3(ok);
    @(negedge clk);
    b_d3 = dv3_cnt; b_r3 = rd3_cnt;
    reset = 1'b0;
    #1;
    check("midrst_rd3", 32'(rd3), 32'd0);
    check("midrst_dout3", 32'(dout3), 32'h0);
    check("midrst_dv3", 32'(dv3), 32'd0);
    check("midrst_busy3", 32'(busy3), 32'd0);
    check("midrst_uf3", 32'(uf3), 32'd0);
    check("midrst_dout1", 32'(dout1), 32'h0);
    pop_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_valid3", dv3_cnt - b_d3, 0);
    check("midrst_no_read3", rd3_cnt - b_r3, 0);
    fifo_data = 8'h5A;
    b_d3 = dv3_cnt;
    pop_n = 1'b0;
    repeat (6) @(negedge clk);
    pop_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_dout3", 32'(dout3), 32'h5A);
    check("post_rst_valid3", dv3_cnt - b_d3, 1);
    check("post_rst_dout1", 32'(dout1), 32'h5A);
    check("post_rst_uf3", 32'(uf3), 32'd0);
    $display("post reset read: dout1=%02h dout3=%02h", dout1, dout3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the FIFO data word and of data_out.
REQ-002 Parameter READ_LATENCY, default 1, legal 1..3, cycles from fifo_read high to valid fifo_data.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state is updated on its rising edge.
REQ-005 reset  input  1  asynchronous active-low reset; low clears all state.
REQ-006 pop_n  input  1  raw pushbutton, low when pressed, asynchronous to clk.
REQ-007 fifo_empty  input  1  FIFO empty flag, synchronous to clk.
REQ-008 fifo_data  input  DATA_WIDTH  FIFO read data, valid READ_LATENCY cycles after fifo_read.
REQ-009 fifo_read  output  1  single-cycle pop strobe to the FIFO.
REQ-010 data_out  output  DATA_WIDTH  last word captured, held until the next capture.
REQ-011 data_valid  output  1  one-cycle pulse in the first cycle data_out shows a new word.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 underflow  output  1  sticky flag for a pop request made while the FIFO is empty (see Configuration).

Function
REQ-014 pop_n shall pass through a 2-flop synchronizer, then a falling-edge detector (press = 1->0 on the synchronized signal), giving a one-cycle pop_req.
REQ-015 Holding the button shall produce exactly one pop_req per press; release produces none.
REQ-016 FSM states: IDLE, ISSUE, WAIT, CAPTURE.
REQ-017 IDLE: on pop_req with fifo_empty=0, go to ISSUE; on pop_req with fifo_empty=1, stay in IDLE, leave fifo_read low, and set underflow.
REQ-018 ISSUE: fifo_read=1 for exactly this one cycle; next state WAIT.
REQ-019 WAIT: a latency counter counts READ_LATENCY-1 cycles, then goes to CAPTURE (READ_LATENCY=1 goes straight to CAPTURE).
REQ-020 CAPTURE: latch fifo_data into data_out; next state IDLE.
REQ-021 Timing: fifo_read high in cycle t; fifo_data sampled at the end of cycle t+READ_LATENCY; data_out updates and data_valid=1 in cycle t+READ_LATENCY+1 only.
REQ-022 Any pop_req arriving while busy=1 shall be dropped, with no queuing and no underflow.
REQ-023 fifo_empty is checked only in IDLE on the pop_req cycle; a change of fifo_empty after ISSUE shall not abort the capture.
REQ-024 fifo_read shall never be high for two consecutive cycles and never while fifo_empty=1 in the same cycle.
REQ-025 underflow stays set until reset.

Reset
REQ-026 Asserting reset at any time, including mid-transaction, forces within the same cycle: state=IDLE, fifo_read=0, data_out=0, data_valid=0, busy=0, underflow=0, synchronizer flops=1 (released), latency counter=0.
REQ-027 After reset deasserts, no pop_req shall be generated unless a new press (1->0) is seen on the synchronized input.

Configuration
REQ-028 With macro FIFO_READER_UNDERFLOW_EN defined, underflow detection is built as specified in REQ-017 and REQ-025.
REQ-029 Without FIFO_READER_UNDERFLOW_EN, underflow is tied to 0, its flop is omitted, and all other behaviour is unchanged.

Verification
REQ-030 Reset; hold fifo_empty=0 and fifo_data=8'hA5; press pop_n -> exactly one fifo_read pulse, 2 cycles after the synchronized edge data_out=8'hA5, data_valid pulses once (READ_LATENCY=1).
REQ-031 READ_LATENCY=3; fifo_data becomes 8'h3C 3 cycles after fifo_read -> data_out=8'h3C exactly 4 cycles after fifo_read, busy high for 4 cycles.
REQ-032 fifo_empty=1; press -> fifo_read stays 0, data_out unchanged, underflow=1 when the macro is defined, underflow=0 when it is not.
REQ-033 Hold pop_n low for 100 cycles, then press a second time while busy -> exactly one fifo_read in total.
REQ-034 Assert reset during WAIT (READ_LATENCY=3) -> all outputs 0 immediately, no data_valid pulse, and after release a new press produces a normal read.
REQ-035 Four presses spaced 10 cycles apart with FIFO words 8'h01..8'h04 -> data_out shows 01, 02, 03, 04 in order, with 4 data_valid pulses.
